// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the 4-requester mux arbiter.
package mux_arb_pkg;

   localparam int unsigned N_REQ = 4;
   localparam int unsigned SEL_W = 2;

   typedef enum logic [0:0] {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_t;

   // One-hot grant vector for a given select index.
   function automatic logic [N_REQ-1:0] sel_to_onehot(input logic [SEL_W-1:0] s);
      return N_REQ'(1) << s;
   endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick4.sv
// Combinational 4-way winner picker.
// Default: round-robin starting after ptr.
// MUX_ARB_FIXED_PRIO_EN: fixed priority, lowest set index wins (ptr ignored).
module rr_pick4
   import mux_arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] ptr,
   output logic [SEL_W-1:0] idx,
   output logic             found
);

`ifdef MUX_ARB_FIXED_PRIO_EN

   logic unused_ptr;
   assign unused_ptr = ^ptr;

   // Scan from the top so the lowest set index is the last one written.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx   = SEL_W'(i);
            found = 1'b1;
         end
      end
   end

`else

   logic [SEL_W-1:0] cand;

   // Offsets ptr+4 (== ptr) down to ptr+1; the nearest offset is written last and wins.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      for (int k = int'(N_REQ); k >= 1; k--) begin
         cand = ptr + SEL_W'(k);
         if (req[cand]) begin
            idx   = cand;
            found = 1'b1;
         end
      end
   end

`endif

endmodule

// File: rtl/mux_rr_arbiter.sv
// Four-requester arbiter and select controller for a 4:1 mux channel.
// Grants one requester for up to MAX_BURST beats, then rearbitrates via one IDLE cycle.
// Optional macro MUX_ARB_FIXED_PRIO_EN switches the picker to fixed priority.
module mux_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   output logic [N_REQ-1:0]        req_ready,
   output logic                    out_valid,
   output logic [DATA_W-1:0]       out_data,
   input  logic                    out_ready,
   output logic [SEL_W-1:0]        sel,
   output logic [N_REQ-1:0]        grant,
   output logic                    busy
);

   localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

   arb_state_t       state_q;
   logic [SEL_W-1:0] sel_q;
   logic [SEL_W-1:0] ptr_q;
   logic [N_REQ-1:0] grant_q;
   logic             busy_q;
   logic [CNT_W-1:0] beat_cnt_q;
   logic [CNT_W-1:0] beat_cnt_d;

   logic [SEL_W-1:0] pick_idx;
   logic             pick_found;
   logic             in_grant;
   logic             sel_valid;
   logic             beat;
   logic             last_beat;

   rr_pick4 u_pick (
      .req   (req_valid),
      .ptr   (ptr_q),
      .idx   (pick_idx),
      .found (pick_found)
   );

   // Handshake qualifiers for the currently granted requester.
   always_comb begin
      in_grant   = (state_q == ARB_GRANT);
      sel_valid  = req_valid[sel_q];
      beat       = in_grant && sel_valid && out_ready;
      last_beat  = beat && (beat_cnt_q == CNT_W'(MAX_BURST - 1));
      beat_cnt_d = beat ? beat_cnt_q + CNT_W'(1) : beat_cnt_q;
   end

   // Output channel: data mux on sel, valid/ready only while granted.
   always_comb begin
      out_data = '0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         if (sel_q == SEL_W'(i)) begin
            out_data = req_data[i*DATA_W +: DATA_W];
         end
      end
      out_valid = in_grant && sel_valid;
      req_ready = in_grant ? (grant_q & {N_REQ{out_ready}}) : '0;
   end

   // Arbitration FSM with registered select, grant and busy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ARB_IDLE;
         sel_q      <= '0;
         ptr_q      <= SEL_W'(N_REQ - 1);
         grant_q    <= '0;
         busy_q     <= 1'b0;
         beat_cnt_q <= '0;
      end else if (state_q == ARB_IDLE) begin
         if (pick_found) begin
            state_q    <= ARB_GRANT;
            sel_q      <= pick_idx;
            ptr_q      <= pick_idx;
            grant_q    <= sel_to_onehot(pick_idx);
            busy_q     <= 1'b1;
            beat_cnt_q <= '0;
         end
      end else begin
         beat_cnt_q <= beat_cnt_d;
         if (!sel_valid || last_beat) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
         end
      end
   end

   assign sel   = sel_q;
   assign grant = grant_q;
   assign busy  = busy_q;

endmodule
